// File: rtl/mem_port_sched.sv
// Time-shares one single-port memory between instruction fetch and data access,
// holding the core with `stall` until each instruction commits. `MPS_TIMEOUT_EN adds a bus watchdog.
module mem_port_sched #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            stall,
  output logic            bus_err
);

  typedef enum logic [2:0] {FETCH, FWAIT, DECODE, DATA, DWAIT, COMMIT, HALT} state_t;

  state_t state, state_nxt;
  logic   m_req_c;
  logic   dwe_q;

`ifdef MPS_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd;
  logic           wait_cyc;

  // Cycles spent waiting on the grant or response the current state needs.
  assign wait_cyc = ((state == FETCH || state == DATA) && !m_gnt) ||
                    ((state == FWAIT || state == DWAIT) && !m_rvalid);
`endif

  always_comb begin
    state_nxt = state;
    m_req_c   = 1'b0;
    m_we      = 1'b0;
    m_be      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    stall     = 1'b1;
    case (state)
      FETCH: begin
        m_req_c = 1'b1;
        m_be    = '1;
        m_addr  = i_addr;
        if (m_gnt) state_nxt = FWAIT;
      end
      FWAIT:  if (m_rvalid) state_nxt = DECODE;
      DECODE: state_nxt = d_req ? DATA : COMMIT;
      DATA: begin
        m_req_c = 1'b1;
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        if (m_gnt) state_nxt = DWAIT;
      end
      DWAIT:  if (m_rvalid) state_nxt = COMMIT;
      COMMIT: begin
        stall     = 1'b0;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
`ifdef MPS_TIMEOUT_EN
    if (wait_cyc && wd == WDW'(TIMEOUT - 1)) state_nxt = HALT;
`endif
  end

  // The request must drop as soon as reset is seen, not one cycle later.
  assign m_req = m_req_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      i_rdata <= '0;
      d_rdata <= '0;
      dwe_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FWAIT && m_rvalid) i_rdata <= m_rdata;
      // Direction is captured at grant so DWAIT does not depend on d_we.
      if (state == DATA && m_gnt) dwe_q <= d_we;
      if (state == DWAIT && m_rvalid && !dwe_q) d_rdata <= m_rdata;
    end
  end

`ifdef MPS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state_nxt != state) wd <= '0;
      else if (wait_cyc)      wd <= wd + 1'b1;
      if (state_nxt == HALT)  bus_err <= 1'b1;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule
